// File: rtl/axi4lite_mem_slave.sv
// axi4lite_mem_slave
//   AXI4-Lite responder backed by a word-addressed on-chip memory. It serves
//   as scratch RAM and as the target for bridge traffic. The read and write
//   paths are independent, and at most one transaction of each kind is in
//   flight at a time. All outputs come straight from registers.
//   Ports:
//     axi_clk, axi_arstn        : clock and asynchronous active-low reset
//     s_aw* / s_w* / s_b*       : write address, write data, write response
//     s_ar* / s_r*              : read address, read data
//   Responses: OKAY (2'b00), or DECERR (2'b11) when the address falls outside
//   the window [BASE_ADDR, BASE_ADDR + DEPTH*STRB_WIDTH).
module axi4lite_mem_slave #(
    parameter int                    ADDR_WIDTH     = 64,
    parameter int                    AXI_DATA_WIDTH = 64,
    parameter int                    STRB_WIDTH     = AXI_DATA_WIDTH / 8,
    parameter int                    DEPTH          = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                      axi_clk,
    input  logic                      axi_arstn,
    input  logic [ADDR_WIDTH-1:0]     s_araddr,
    input  logic [2:0]                s_arprot,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [AXI_DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    input  logic [ADDR_WIDTH-1:0]     s_awaddr,
    input  logic [2:0]                s_awprot,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [AXI_DATA_WIDTH-1:0] s_wdata,
    input  logic [STRB_WIDTH-1:0]     s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic                      s_bvalid,
    output logic [1:0]                s_bresp,
    input  logic                      s_bready
);

    localparam int                    LSB   = $clog2(STRB_WIDTH);
    localparam int                    IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(DEPTH * STRB_WIDTH);
    localparam logic [1:0]            OKAY  = 2'b00;
    localparam logic [1:0]            DECERR = 2'b11;

    logic [AXI_DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write holding buffers
    logic                      r_aw_full, r_w_full;
    logic [ADDR_WIDTH-1:0]     r_aw_addr;
    logic [AXI_DATA_WIDTH-1:0] r_w_data;
    logic [STRB_WIDTH-1:0]     r_w_strb;

    logic                      r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]                r_bresp, r_rresp;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;

    // The offset is computed one bit wider than the address so that the top
    // bit acts as a borrow flag: a set borrow means the address lies below
    // BASE_ADDR.
    logic [ADDR_WIDTH:0]  w_aw_diff, w_ar_diff;
    logic                 w_aw_hit, w_ar_hit;
    logic [IDX_W-1:0]     w_aw_idx, w_ar_idx;
    logic                 w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs, w_commit;
    logic                 w_unused;

    assign w_aw_diff = {1'b0, r_aw_addr} - {1'b0, BASE_ADDR};
    assign w_ar_diff = {1'b0, s_araddr}  - {1'b0, BASE_ADDR};
    assign w_aw_hit  = ~w_aw_diff[ADDR_WIDTH] && (w_aw_diff[ADDR_WIDTH-1:0] < SPAN);
    assign w_ar_hit  = ~w_ar_diff[ADDR_WIDTH] && (w_ar_diff[ADDR_WIDTH-1:0] < SPAN);
    assign w_aw_idx  = w_aw_diff[LSB +: IDX_W];
    assign w_ar_idx  = w_ar_diff[LSB +: IDX_W];

    assign w_aw_hs  = s_awvalid & r_awready;
    assign w_w_hs   = s_wvalid  & r_wready;
    assign w_ar_hs  = s_arvalid & r_arready;
    assign w_b_hs   = r_bvalid  & s_bready;
    assign w_r_hs   = r_rvalid  & s_rready;
    assign w_commit = r_aw_full & r_w_full & ~r_bvalid;

    // The protection bits and the byte-lane and upper offset bits play no
    // part in the decode.
    assign w_unused = ^{s_arprot, s_awprot, w_aw_diff, w_ar_diff};

    // Memory is deliberately left out of reset. During reset the buffers are
    // empty, so w_commit is low and no write can occur.
    always_ff @(posedge axi_clk) begin
        if (w_commit && w_aw_hit) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (r_w_strb[i]) r_mem[w_aw_idx][8*i +: 8] <= r_w_data[8*i +: 8];
            end
        end
    end

    // Write channel control
    always_ff @(posedge axi_clk or negedge axi_arstn) begin
        if (!axi_arstn) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_aw_addr <= '0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_addr <= s_awaddr;
                r_aw_full <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_data <= s_wdata;
                r_w_strb <= s_wstrb;
                r_w_full <= 1'b1;
            end
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_aw_hit ? OKAY : DECERR;
            end
            if (w_b_hs) begin
                r_bvalid <= 1'b0;
                r_bresp  <= OKAY;
            end
            // A ready stays low from its handshake until the B response
            // completes. The idle term (empty buffer with no B pending) raises
            // the readies on the first edge after reset.
            if (w_aw_hs)                        r_awready <= 1'b0;
            else if (w_b_hs)                    r_awready <= 1'b1;
            else if (!r_aw_full && !r_bvalid)   r_awready <= 1'b1;
            if (w_w_hs)                         r_wready  <= 1'b0;
            else if (w_b_hs)                    r_wready  <= 1'b1;
            else if (!r_w_full && !r_bvalid)    r_wready  <= 1'b1;
        end
    end

    // Read channel control. The non-blocking read of r_mem returns the
    // pre-write word when a commit hits the same word on the same edge.
    always_ff @(posedge axi_clk or negedge axi_arstn) begin
        if (!axi_arstn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= OKAY;
        end else begin
            if (w_ar_hs) begin
                r_arready <= 1'b0;
                r_rvalid  <= 1'b1;
                r_rdata   <= w_ar_hit ? r_mem[w_ar_idx] : '0;
                r_rresp   <= w_ar_hit ? OKAY : DECERR;
            end else if (w_r_hs) begin
                r_rvalid  <= 1'b0;
                r_arready <= 1'b1;
            end else if (!r_rvalid) begin
                r_arready <= 1'b1;
            end
        end
    end

    assign s_awready = r_awready;
    assign s_wready  = r_wready;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_arready = r_arready;
    assign s_rvalid  = r_rvalid;
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;

endmodule

// File: tb/tb_axi4lite_mem_slave.sv
module tb_axi4lite_mem_slave;
    localparam int AW = 64, DW = 64, SW = 8, DEPTH = 256;
    localparam logic [63:0] SPAN_BYTES = 64'(DEPTH * SW);   // base address is 0

    logic          axi_clk, axi_arstn;
    logic [AW-1:0] s_araddr, s_awaddr;
    logic [2:0]    s_arprot, s_awprot;
    logic          s_arvalid, s_arready, s_rvalid, s_rready;
    logic [DW-1:0] s_rdata, s_wdata;
    logic [1:0]    s_rresp, s_bresp;
    logic          s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [SW-1:0] s_wstrb;

    axi4lite_mem_slave #(
        .ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .STRB_WIDTH(SW), .DEPTH(DEPTH), .BASE_ADDR('0)
    ) dut (
        .axi_clk(axi_clk), .axi_arstn(axi_arstn),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    // Reference memory: one 64-bit word per 8-byte address slot
    logic [63:0] model [DEPTH];
    int checks = 0;
    int errors = 0;

    function automatic logic hit(input logic [63:0] a);
        return a < SPAN_BYTES;
    endfunction

    task automatic tick;
        @(posedge axi_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write with AW launched aw_at cycles in, W launched w_at cycles in, and
    // the B response held off for bwait cycles.
    task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] st,
                      input int aw_at, input int w_at, input int bwait);
        bit aw_done = 0, w_done = 0, awhs, whs;
        int t = 0;
        logic [1:0] eresp;
        s_awaddr = a; s_wdata = d; s_wstrb = st;
        while (!(aw_done && w_done) && t < 40) begin
            s_awvalid = !aw_done && (t >= aw_at);
            s_wvalid  = !w_done  && (t >= w_at);
            awhs = s_awvalid && s_awready;
            whs  = s_wvalid  && s_wready;
            tick; t++;
            if (awhs) aw_done = 1;
            if (whs)  w_done  = 1;
            s_awvalid = 1'b0; s_wvalid = 1'b0;
            if (!(aw_done && w_done)) chk("b_before_both", 64'(s_bvalid), 64'd0);
        end
        chk("wr_handshakes", 64'({aw_done, w_done}), 64'd3);
        tick;
        eresp = hit(a) ? 2'b00 : 2'b11;
        chk("bvalid_latency", 64'(s_bvalid), 64'd1);
        chk("bresp", 64'(s_bresp), 64'(eresp));
        if (hit(a)) begin
            for (int i = 0; i < SW; i++)
                if (st[i]) model[int'(a >> 3)][8*i +: 8] = d[8*i +: 8];
        end
        repeat (bwait) begin
            tick;
            chk("bvalid_hold", 64'(s_bvalid), 64'd1);
            chk("bresp_hold", 64'(s_bresp), 64'(eresp));
            chk("awready_busy", 64'(s_awready), 64'd0);
            chk("wready_busy", 64'(s_wready), 64'd0);
        end
        s_bready = 1'b1;
        tick;
        s_bready = 1'b0;
        chk("bvalid_drop", 64'(s_bvalid), 64'd0);
        chk("bresp_clear", 64'(s_bresp), 64'd0);
        chk("awready_back", 64'(s_awready), 64'd1);
        chk("wready_back", 64'(s_wready), 64'd1);
    endtask

    task automatic rd(input logic [63:0] a, input int rwait);
        logic [63:0] exp;
        logic [1:0]  eresp;
        exp   = hit(a) ? model[int'(a >> 3)] : 64'd0;
        eresp = hit(a) ? 2'b00 : 2'b11;
        s_araddr = a; s_arvalid = 1'b1;
        chk("arready_idle", 64'(s_arready), 64'd1);
        tick;
        s_arvalid = 1'b0;
        chk("rvalid", 64'(s_rvalid), 64'd1);
        chk("rdata", s_rdata, exp);
        chk("rresp", 64'(s_rresp), 64'(eresp));
        repeat (rwait) begin
            tick;
            chk("rvalid_hold", 64'(s_rvalid), 64'd1);
            chk("rdata_hold", s_rdata, exp);
            chk("arready_busy", 64'(s_arready), 64'd0);
        end
        s_rready = 1'b1;
        tick;
        s_rready = 1'b0;
        chk("rvalid_drop", 64'(s_rvalid), 64'd0);
        chk("arready_back", 64'(s_arready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] old, ra;
        axi_arstn = 1'b0;
        s_araddr = '0; s_arprot = '0; s_arvalid = 0; s_rready = 0;
        s_awaddr = '0; s_awprot = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0;
        s_wvalid = 0; s_bready = 0;

        // Reset state and release
        repeat (3) tick;
        chk("rst_awready", 64'(s_awready), 64'd0);
        chk("rst_wready", 64'(s_wready), 64'd0);
        chk("rst_arready", 64'(s_arready), 64'd0);
        chk("rst_bvalid", 64'(s_bvalid), 64'd0);
        chk("rst_rvalid", 64'(s_rvalid), 64'd0);
        chk("rst_rdata", s_rdata, 64'd0);
        chk("rst_rresp", 64'(s_rresp), 64'd0);
        chk("rst_bresp", 64'(s_bresp), 64'd0);
        axi_arstn = 1'b1;
        tick;
        chk("rel_awready", 64'(s_awready), 64'd1);
        chk("rel_wready", 64'(s_wready), 64'd1);
        chk("rel_arready", 64'(s_arready), 64'd1);

        // Give every word a known value
        for (int i = 0; i < DEPTH; i++)
            wr(64'(i * 8), {$urandom, $urandom}, 8'hFF, 0, 0, 0);

        // Full write then read back
        wr(64'h10, 64'h1122334455667788, 8'hFF, 0, 0, 0);
        rd(64'h10, 0);

        // W leads AW by three cycles with the low strobes only
        wr(64'h10, 64'hFFFFFFFFAABBCCDD, 8'h0F, 3, 0, 0);
        chk("partial_model", model[2], 64'h11223344AABBCCDD);
        rd(64'h10, 0);

        // AW leads W, then B backpressure
        wr(64'h28, 64'h0123456789ABCDEF, 8'hA5, 0, 2, 0);
        rd(64'h28, 1);
        wr(64'h20, 64'hCAFEF00DDEADBEEF, 8'hFF, 0, 0, 5);
        rd(64'h20, 0);

        // Decode error: memory is untouched and reads return zero with DECERR
        wr(64'h800, 64'h11, 8'hFF, 0, 0, 0);
        rd(64'h800, 0);
        rd(64'hFFFF_FFFF_FFFF_FFF8, 0);
        for (int i = 0; i < DEPTH; i++) rd(64'(i * 8), 0);

        // Read lands on the same edge as a commit to that word
        s_awaddr = 64'h10; s_wdata = 64'h5A5A5A5A5A5A5A5A; s_wstrb = 8'hFF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        tick;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_araddr = 64'h10; s_arvalid = 1'b1;
        chk("rbw_arready", 64'(s_arready), 64'd1);
        old = model[2];
        tick;
        s_arvalid = 1'b0;
        chk("rbw_bvalid", 64'(s_bvalid), 64'd1);
        chk("rbw_rvalid", 64'(s_rvalid), 64'd1);
        chk("rbw_old_data", s_rdata, old);
        model[2] = 64'h5A5A5A5A5A5A5A5A;
        s_bready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            s_bready = 1'b0;
            chk("rbw_rdata_hold", s_rdata, old);
            chk("rbw_arready_busy", 64'(s_arready), 64'd0);
        end
        chk("rbw_b_done", 64'(s_bvalid), 64'd0);
        s_rready = 1'b1;
        tick;
        s_rready = 1'b0;
        chk("rbw_rvalid_drop", 64'(s_rvalid), 64'd0);
        rd(64'h10, 0);

        // Reset in the middle of a write discards the buffered address
        s_awaddr = 64'h18; s_awvalid = 1'b1;
        tick;
        s_awvalid = 1'b0;
        chk("mid_awready", 64'(s_awready), 64'd0);
        axi_arstn = 1'b0;
        #1;
        chk("mid_rst_wready", 64'(s_wready), 64'd0);
        chk("mid_rst_arready", 64'(s_arready), 64'd0);
        tick;
        axi_arstn = 1'b1;
        tick;
        chk("mid_rel_awready", 64'(s_awready), 64'd1);
        chk("mid_rel_wready", 64'(s_wready), 64'd1);
        rd(64'h18, 0);

        // Randomized mix of reads and writes
        repeat (80) begin
            case ($urandom_range(0, 9))
                0:       ra = 64'h800 + 64'($urandom_range(0, 255));
                1:       ra = {$urandom, $urandom} | 64'h1_0000_0000;
                default: ra = 64'($urandom_range(0, DEPTH * SW - 1));
            endcase
            if ($urandom_range(0, 1) == 1)
                wr(ra, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3));
            else
                rd(ra, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
